// File: rtl/stage4_message_drain.sv
// Stage-4 message drain: packs valid bundle slots into a circular FIFO
// and streams them one message per cycle; whole bundles drop on overflow.
module stage4_message_drain #(
    parameter int MSG_W   = 64,
    parameter int NTYPE_W = 4,
    parameter int MUX_W   = 3,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               message_en_in,
    input  logic [MSG_W-1:0]   message_1_in,
    input  logic [MSG_W-1:0]   message_2_in,
    input  logic [MSG_W-1:0]   message_3_in,
    input  logic [NTYPE_W-1:0] N_type_control_m1_in,
    input  logic [NTYPE_W-1:0] N_type_control_m2_in,
    input  logic [NTYPE_W-1:0] N_type_control_m3_in,
    input  logic [MUX_W-1:0]   message_mux_control_m1_in,
    input  logic [MUX_W-1:0]   message_mux_control_m2_in,
    input  logic [MUX_W-1:0]   message_mux_control_m3_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MSG_W-1:0]   out_message,
    output logic [NTYPE_W-1:0] out_N_type,
    output logic [MUX_W-1:0]   out_mux,
    output logic               in_stall,
    output logic               overflow,
    output logic [CNT_W-1:0]   drop_cnt,
    input  logic               stats_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [MSG_W-1:0]   mem_msg [DEPTH];
    logic [NTYPE_W-1:0] mem_nt  [DEPTH];
    logic [MUX_W-1:0]   mem_mux [DEPTH];

    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic          v1, v2, v3, pop, push_ok, drop;
    logic [1:0]    nv;
    logic [CW-1:0] free;
    logic [PW-1:0] a1, a2, a3;

    assign v1 = message_en_in && (message_mux_control_m1_in != '0);
    assign v2 = message_en_in && (message_mux_control_m2_in != '0);
    assign v3 = message_en_in && (message_mux_control_m3_in != '0);
    assign nv = {1'b0, v1} + {1'b0, v2} + {1'b0, v3};

    assign pop  = out_valid && out_ready;
    // A same-cycle pop frees one slot for the incoming bundle.
    assign free = CW'(DEPTH) - cnt_q + {{(CW-1){1'b0}}, pop};

    assign push_ok = (nv != 2'd0) && ({{(CW-2){1'b0}}, nv} <= free);
    assign drop    = (nv != 2'd0) && !push_ok;

    // Valid slots are compacted: each lands after the valid ones before it.
    assign a1 = wr_q;
    assign a2 = wr_q + PW'(v1);
    assign a3 = wr_q + PW'(v1) + PW'(v2);

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (push_ok) begin
            wr_d  = wr_q + PW'(nv);
            cnt_d = cnt_q + CW'(nv);
        end
        if (pop) begin
            rd_d  = rd_q + PW'(1);
            cnt_d = cnt_d - CW'(1);
        end
        if (stats_clr) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            if (v1) begin
                mem_msg[a1] <= message_1_in;
                mem_nt[a1]  <= N_type_control_m1_in;
                mem_mux[a1] <= message_mux_control_m1_in;
            end
            if (v2) begin
                mem_msg[a2] <= message_2_in;
                mem_nt[a2]  <= N_type_control_m2_in;
                mem_mux[a2] <= message_mux_control_m2_in;
            end
            if (v3) begin
                mem_msg[a3] <= message_3_in;
                mem_nt[a3]  <= N_type_control_m3_in;
                mem_mux[a3] <= message_mux_control_m3_in;
            end
        end
    end

    // Outputs read as zero while empty so post-reset values are defined.
    assign out_valid   = (cnt_q != '0);
    assign out_message = out_valid ? mem_msg[rd_q] : '0;
    assign out_N_type  = out_valid ? mem_nt[rd_q]  : '0;
    assign out_mux     = out_valid ? mem_mux[rd_q] : '0;
    assign in_stall    = (cnt_q > CW'(DEPTH - 3));
    assign overflow    = ovf_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_stage4_message_drain.sv
// Bench for stage4_message_drain: queue-based reference model compared
// every cycle, plus hand-computed directed expectations.
module tb_stage4_message_drain;

    localparam int MW = 16;
    localparam int NW = 4;
    localparam int XW = 3;
    localparam int D  = 8;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [MW-1:0] m1 = '0, m2 = '0, m3 = '0;
    logic [NW-1:0] n1 = '0, n2 = '0, n3 = '0;
    logic [XW-1:0] x1 = '0, x2 = '0, x3 = '0;
    logic          out_valid, out_ready = 1'b0;
    logic [MW-1:0] out_message;
    logic [NW-1:0] out_N_type;
    logic [XW-1:0] out_mux;
    logic          in_stall, overflow, stats_clr = 1'b0;
    logic [CW-1:0] drop_cnt;

    stage4_message_drain #(
        .MSG_W(MW), .NTYPE_W(NW), .MUX_W(XW), .DEPTH(D), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .message_en_in(en),
        .message_1_in(m1), .message_2_in(m2), .message_3_in(m3),
        .N_type_control_m1_in(n1), .N_type_control_m2_in(n2),
        .N_type_control_m3_in(n3),
        .message_mux_control_m1_in(x1), .message_mux_control_m2_in(x2),
        .message_mux_control_m3_in(x3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_message(out_message), .out_N_type(out_N_type),
        .out_mux(out_mux), .in_stall(in_stall), .overflow(overflow),
        .drop_cnt(drop_cnt), .stats_clr(stats_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [MW-1:0] m;
        logic [NW-1:0] n;
        logic [XW-1:0] x;
    } ent_t;

    ent_t mq[$];
    ent_t inb[$];
    int   m_drop = 0;
    bit   m_ovf = 0;
    int   free;
    bit   mpop;

    int n_cmp = 0;
    int n_bad = 0;
    logic [MW-1:0] tag = 16'h0100;

    // Reference: a bundle is the list of its nonzero-mux slots in order;
    // it is appended whole if it fits in free space (after this cycle's pop).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_ovf = 0;
            m_drop = 0;
        end else begin
            inb.delete();
            if (en) begin
                if (x1 != 0) inb.push_back(ent_t'({m1, n1, x1}));
                if (x2 != 0) inb.push_back(ent_t'({m2, n2, x2}));
                if (x3 != 0) inb.push_back(ent_t'({m3, n3, x3}));
            end
            mpop = (mq.size() != 0) && out_ready;
            free = D - mq.size() + int'(mpop);
            if (mpop) void'(mq.pop_front());
            if (inb.size() <= free) begin
                foreach (inb[i]) mq.push_back(inb[i]);
            end else if (!stats_clr) begin
                m_ovf = 1;
                if (m_drop < SAT) m_drop++;
            end
            if (stats_clr) begin
                m_ovf = 0;
                m_drop = 0;
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic check_model();
        cmp("valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            cmp("msg", 32'(out_message), 32'(mq[0].m));
            cmp("ntype", 32'(out_N_type), 32'(mq[0].n));
            cmp("mux", 32'(out_mux), 32'(mq[0].x));
        end
        cmp("stall", 32'(in_stall), 32'(mq.size() > D - 3));
        cmp("ovf", 32'(overflow), 32'(m_ovf));
        cmp("drop", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        check_model();
    endtask

    task automatic bundle(input bit e, input logic [XW-1:0] a,
                          input logic [XW-1:0] b, input logic [XW-1:0] c);
        en = e;
        m1 = tag;
        m2 = tag + 16'd1;
        m3 = tag + 16'd2;
        tag = tag + 16'd3;
        n1 = NW'($urandom);
        n2 = NW'($urandom);
        n3 = NW'($urandom);
        x1 = a;
        x2 = b;
        x3 = c;
    endtask

    task automatic idle();
        bundle(0, 0, 0, 0);
    endtask

    function automatic logic [XW-1:0] rmux();
        if ($urandom_range(0, 2) == 0) return '0;
        return XW'($urandom_range(1, (1 << XW) - 1));
    endfunction

    logic [MW-1:0] t0;

    initial begin
        idle();
        step();
        step();
        cmp("rst_valid", 32'(out_valid), 0);
        cmp("rst_msg", 32'(out_message), 0);
        cmp("rst_ovf", 32'(overflow), 0);
        cmp("rst_drop", 32'(drop_cnt), 0);
        cmp("rst_stall", 32'(in_stall), 0);
        rst = 1'b0;

        // Sparse bundle: slot 2 empty
        out_ready = 1'b1;
        t0 = tag;
        bundle(1, 1, 0, 2);
        step();
        idle();
        cmp("sparse_v1", 32'(out_valid), 1);
        cmp("sparse_m1", 32'(out_message), 32'(t0));
        cmp("sparse_x1", 32'(out_mux), 1);
        step();
        cmp("sparse_m3", 32'(out_message), 32'(t0 + 16'd2));
        cmp("sparse_x3", 32'(out_mux), 2);
        step();
        cmp("sparse_end", 32'(out_valid), 0);

        // Overflow: three full bundles, no draining
        out_ready = 1'b0;
        bundle(1, 1, 2, 3);
        step();
        cmp("ovf_stall1", 32'(in_stall), 0);
        bundle(1, 4, 5, 6);
        step();
        cmp("ovf_stall2", 32'(in_stall), 1);
        bundle(1, 7, 1, 2);
        step();
        idle();
        cmp("ovf_flag", 32'(overflow), 1);
        cmp("ovf_cnt", 32'(drop_cnt), 1);

        // Clear stats, then full bundle alongside a pop at count 6
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        cmp("clr_ovf", 32'(overflow), 0);
        cmp("clr_cnt", 32'(drop_cnt), 0);
        out_ready = 1'b1;
        bundle(1, 3, 3, 3);
        step();
        idle();
        out_ready = 1'b0;
        cmp("credit_ovf", 32'(overflow), 0);
        cmp("credit_cnt", 32'(drop_cnt), 0);
        cmp("credit_stall", 32'(in_stall), 1);

        // Saturation of the drop counter, then clear with concurrent drop
        repeat (SAT + 3) begin
            bundle(1, 1, 1, 1);
            step();
        end
        cmp("sat_cnt", 32'(drop_cnt), SAT);
        cmp("sat_ovf", 32'(overflow), 1);
        stats_clr = 1'b1;
        bundle(1, 1, 1, 1);
        step();
        stats_clr = 1'b0;
        cmp("clrdrop_ovf", 32'(overflow), 0);
        cmp("clrdrop_cnt", 32'(drop_cnt), 0);

        // Async reset while full and flagged
        step();
        rst = 1'b1;
        #1;
        cmp("arst_valid", 32'(out_valid), 0);
        cmp("arst_ovf", 32'(overflow), 0);
        cmp("arst_cnt", 32'(drop_cnt), 0);
        cmp("arst_stall", 32'(in_stall), 0);
        idle();
        step();
        rst = 1'b0;
        t0 = tag + 16'd1;
        bundle(1, 0, 5, 0);
        step();
        idle();
        cmp("post_rst_v", 32'(out_valid), 1);
        cmp("post_rst_m", 32'(out_message), 32'(t0));
        cmp("post_rst_x", 32'(out_mux), 5);

        // Random traffic across many pointer wraps
        repeat (400) begin
            if ($urandom_range(0, 3) != 0) bundle(1, rmux(), rmux(), rmux());
            else idle();
            out_ready = $urandom_range(0, 1) == 1;
            stats_clr = $urandom_range(0, 49) == 0;
            step();
        end
        idle();
        stats_clr = 1'b0;
        out_ready = 1'b1;
        repeat (D + 2) step();
        cmp("drain_empty", 32'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
